fetch_sequencer: RTL and testbench

- Consumer of the PC register's output and producer of its next-address input; it closes the loop around the PC.
- Reads the current PC, fetches the instruction word at that address over a request/acknowledge handshake to instruction memory, and holds it for the decoder.
- Once the decoder accepts the word, it computes the next PC (sequential, branch, jump or flush) and pulses a load strobe into the PC.

---
 rtl/fetch_pkg.sv | 33 +++
 rtl/fetch_sequencer_next_pc_calc.sv | 33 +++
 rtl/fetch_sequencer.sv | 141 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
package fetch_pkg;

  localparam int unsigned AW_DEF      = 16;
  localparam int unsigned DW_DEF      = 16;
  localparam int unsigned TIMEOUT_DEF = 15;
  localparam logic [15:0] RESET_VEC_DEF = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    UPDATE
  } state_t;

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_JMP,
    SEL_FLUSH
  } pc_sel_t;

  // Redirect priority: flush > jump > taken branch > sequential.
  function automatic pc_sel_t pc_select(input logic flush, input logic jmp, input logic br_taken);
    pc_sel_t sel;
    if (flush)         sel = SEL_FLUSH;
    else if (jmp)      sel = SEL_JMP;
    else if (br_taken) sel = SEL_BR;
    else               sel = SEL_SEQ;
    return sel;
  endfunction

endpackage

// File: rtl/fetch_sequencer_next_pc_calc.sv
// Combinational next-PC target: sequential, relative branch, absolute jump or flush.
module next_pc_calc
  import fetch_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
) (
  input  logic [AW-1:0] pc_in,
  input  logic          br_taken,
  input  logic [7:0]    br_off,
  input  logic          jmp,
  input  logic [AW-1:0] jmp_target,
  input  logic          flush,
  input  logic [AW-1:0] flush_target,
  output logic [AW-1:0] target
);

  pc_sel_t       sel;
  logic [AW-1:0] seq_pc;
  logic [AW-1:0] off_ext;

  always_comb begin
    sel     = pc_select(flush, jmp, br_taken);
    seq_pc  = pc_in + AW'(1);
    off_ext = {{(AW-8){br_off[7]}}, br_off};
    case (sel)
      SEL_FLUSH: target = flush_target;
      SEL_JMP:   target = jmp_target;
      SEL_BR:    target = seq_pc + off_ext;
      default:   target = seq_pc;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Closes the loop around the PC: fetch at pc_in, hold the word for the decoder,
// then strobe the computed next PC back into the PC register.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned   AW        = AW_DEF,
  parameter int unsigned   DW        = DW_DEF,
  parameter logic [AW-1:0] RESET_VEC = AW'(RESET_VEC_DEF),
  parameter int unsigned   TIMEOUT   = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] pc_in,
  output logic [AW-1:0] next_pc,
  output logic          pc_we,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [DW-1:0] imem_data,
  output logic [DW-1:0] instr,
  output logic          instr_valid,
  input  logic          dec_ready,
  input  logic          br_taken,
  input  logic [7:0]    br_off,
  input  logic          jmp,
  input  logic [AW-1:0] jmp_target,
  input  logic          flush,
  input  logic [AW-1:0] flush_target,
  output logic          fetch_err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flush_pend_q, flush_pend_d;
  logic [AW-1:0] pend_target_q, pend_target_d;
  logic [AW-1:0] next_pc_d;
  logic          pc_we_d, imem_req_d, instr_valid_d, fetch_err_d;
  logic [DW-1:0] instr_d;
  logic [AW-1:0] calc_target;

  assign imem_addr = pc_in;

  next_pc_calc #(.AW(AW)) u_calc (
    .pc_in        (pc_in),
    .br_taken     (br_taken),
    .br_off       (br_off),
    .jmp          (jmp),
    .jmp_target   (jmp_target),
    .flush        (flush),
    .flush_target (flush_target),
    .target       (calc_target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      flush_pend_q  <= 1'b0;
      pend_target_q <= '0;
      next_pc       <= RESET_VEC;
      pc_we         <= 1'b0;
      imem_req      <= 1'b0;
      instr         <= '0;
      instr_valid   <= 1'b0;
      fetch_err     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      flush_pend_q  <= flush_pend_d;
      pend_target_q <= pend_target_d;
      next_pc       <= next_pc_d;
      pc_we         <= pc_we_d;
      imem_req      <= imem_req_d;
      instr         <= instr_d;
      instr_valid   <= instr_valid_d;
      fetch_err     <= fetch_err_d;
    end
  end

  // Registered outputs are decoded from the state being entered, so each is
  // stable for exactly the cycles spent in that state.
  always_comb begin
    state_d       = state_q;
    flush_pend_d  = flush_pend_q;
    pend_target_d = pend_target_q;
    next_pc_d     = next_pc;
    instr_d       = instr;
    fetch_err_d   = fetch_err;

    case (state_q)
      IDLE: begin
        state_d   = UPDATE;
        next_pc_d = flush ? flush_target : RESET_VEC;
      end
      REQ: begin
        if (flush) begin
          flush_pend_d  = 1'b1;
          pend_target_d = flush_target;
        end
        if (imem_ack) begin
          if (flush || flush_pend_q) begin
            // Redirected fetch: the returned word is dropped.
            state_d      = UPDATE;
            next_pc_d    = flush ? flush_target : pend_target_q;
            flush_pend_d = 1'b0;
          end else begin
            state_d = HOLD;
            instr_d = imem_data;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // A pending redirect still wins over retrying the stalled address.
          state_d      = UPDATE;
          fetch_err_d  = 1'b1;
          flush_pend_d = 1'b0;
          if (flush)             next_pc_d = flush_target;
          else if (flush_pend_q) next_pc_d = pend_target_q;
          else                   next_pc_d = pc_in;
        end
      end
      HOLD: begin
        if (flush || dec_ready) begin
          state_d   = UPDATE;
          next_pc_d = calc_target;
        end
      end
      UPDATE: begin
        if (flush) next_pc_d = flush_target;
        else       state_d   = REQ;
      end
      default: state_d = IDLE;
    endcase

    cnt_d         = (state_q == REQ) ? cnt_q + CW'(1) : '0;
    pc_we_d       = (state_d == UPDATE);
    imem_req_d    = (state_d == REQ);
    instr_valid_d = (state_d == HOLD);
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a PC register and memory model and
// scoreboard queues for next_pc strobes and delivered instruction words.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic [15:0] pc;
  logic [15:0] next_pc;
  logic        pc_we;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [15:0] instr;
  logic        instr_valid;
  logic        dec_ready;
  logic        br_taken;
  logic [7:0]  br_off;
  logic        jmp;
  logic [15:0] jmp_target;
  logic        flush;
  logic [15:0] flush_target;
  logic        fetch_err;

  int          n_tests;
  int          n_fail;
  int          cyc;
  int          last_we_cyc;
  int          ack_delay;
  int          req_cycles;
  logic        prev_valid;
  logic [15:0] exp_pc[$];
  logic [15:0] exp_instr[$];
  int          periods[$];

  fetch_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_in        (pc),
    .next_pc      (next_pc),
    .pc_we        (pc_we),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_data    (imem_data),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .dec_ready    (dec_ready),
    .br_taken     (br_taken),
    .br_off       (br_off),
    .jmp          (jmp),
    .jmp_target   (jmp_target),
    .flush        (flush),
    .flush_target (flush_target),
    .fetch_err    (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h1111;
      16'h0001: return 16'h2222;
      default:  return a ^ 16'h5A5A;
    endcase
  endfunction

  // PC register closing the loop, and a memory that acks after ack_delay wait cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)     pc <= 16'h0000;
    else if (pc_we) pc <= next_pc;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) req_cycles <= 0;
    else        req_cycles <= imem_req ? req_cycles + 1 : 0;
  end

  assign imem_ack  = imem_req && (ack_delay >= 0) && (req_cycles >= ack_delay);
  assign imem_data = mem_word(imem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: sample at the falling edge and retire scoreboard entries.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (pc_we) begin
      if (exp_pc.size() == 0) check("pc_we_spurious", 32'(pc_we), 32'd0);
      else                    check("next_pc", 32'(next_pc), 32'(exp_pc.pop_front()));
      if (last_we_cyc >= 0) periods.push_back(cyc - last_we_cyc);
      last_we_cyc = cyc;
    end
    if (instr_valid && !prev_valid && exp_instr.size() > 0)
      check("instr", 32'(instr), 32'(exp_instr.pop_front()));
    prev_valid = instr_valid;
  endtask

  task automatic wait_valid(input logic [15:0] addr);
    exp_instr.push_back(mem_word(addr));
    for (int i = 0; i < 40; i++) begin
      if (instr_valid) break;
      tick();
    end
    check("hold_reached", 32'(instr_valid), 32'd1);
  endtask

  task automatic accept(input string tag, input logic f, input logic [15:0] ft,
                        input logic j, input logic [15:0] jt, input logic b,
                        input logic [7:0] bo, input logic dr, input logic [15:0] exp);
    flush = f; flush_target = ft; jmp = j; jmp_target = jt;
    br_taken = b; br_off = bo; dec_ready = dr;
    exp_pc.push_back(exp);
    tick();
    check(tag, 32'(pc_we), 32'd1);
    flush = 1'b0; jmp = 1'b0; br_taken = 1'b0; dec_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] held;
    int          req_cnt;
    n_tests = 0; n_fail = 0; cyc = 0; last_we_cyc = -1; prev_valid = 1'b0;
    rst_n = 1'b0; dec_ready = 1'b1; br_taken = 1'b0; br_off = 8'h00;
    jmp = 1'b0; jmp_target = 16'h0000; flush = 1'b0; flush_target = 16'h0000;
    ack_delay = 0;

    // Reset values
    tick(); tick();
    check("rst_next_pc", 32'(next_pc), 32'h0000);
    check("rst_pc_we", 32'(pc_we), 32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_instr", 32'(instr), 32'h0000);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_fetch_err", 32'(fetch_err), 32'd0);

    // Zero-wait loop from the reset vector
    exp_pc.push_back(16'h0000); exp_pc.push_back(16'h0001); exp_pc.push_back(16'h0002);
    exp_instr.push_back(16'h1111); exp_instr.push_back(16'h2222);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (exp_pc.size() == 0) break;
    end
    dec_ready = 1'b0;
    check("loop_pulses", 32'(exp_pc.size()), 32'd0);
    check("loop_periods", 32'(periods.size()), 32'd2);
    if (periods.size() >= 2) begin
      check("period_1", 32'(periods[0]), 32'd3);
      check("period_2", 32'(periods[1]), 32'd3);
    end

    // Decoder stall in HOLD
    wait_valid(16'h0002);
    held = instr;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_instr", 32'(instr), 32'(mem_word(16'h0002)));
      check("stall_instr_stable", 32'(instr), 32'(held));
      check("stall_pc_we", 32'(pc_we), 32'd0);
      check("stall_imem_req", 32'(imem_req), 32'd0);
    end
    accept("stall_then_jmp", 1'b0, 16'h0, 1'b1, 16'hFFFF, 1'b0, 8'h00, 1'b1, 16'hFFFF);

    // Wrap, branch arithmetic and priorities
    wait_valid(16'hFFFF);
    accept("seq_wrap", 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 8'h00, 1'b1, 16'h0000);
    wait_valid(16'h0000);
    accept("jmp_0010", 1'b0, 16'h0, 1'b1, 16'h0010, 1'b0, 8'h00, 1'b1, 16'h0010);
    wait_valid(16'h0010);
    accept("br_neg", 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 8'hF8, 1'b1, 16'h0009);
    wait_valid(16'h0009);
    accept("jmp_over_br", 1'b0, 16'h0, 1'b1, 16'h0400, 1'b1, 8'hF8, 1'b1, 16'h0400);
    wait_valid(16'h0400);
    accept("jmp_0002", 1'b0, 16'h0, 1'b1, 16'h0002, 1'b0, 8'h00, 1'b1, 16'h0002);
    wait_valid(16'h0002);
    accept("br_wrap", 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 8'hF8, 1'b1, 16'hFFFB);

    // Flush in HOLD without decoder accept drops the word
    wait_valid(16'hFFFB);
    accept("flush_hold", 1'b1, 16'h0300, 1'b1, 16'h0700, 1'b0, 8'h00, 1'b0, 16'h0300);
    check("flush_hold_drop", 32'(instr_valid), 32'd0);

    // Flush in REQ with ack delayed three cycles
    wait_valid(16'h0300);
    ack_delay = 3;
    accept("seq_0301", 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 8'h00, 1'b1, 16'h0301);
    tick();
    check("req_addr", 32'(imem_addr), 32'h0301);
    flush = 1'b1; flush_target = 16'h0200;
    exp_pc.push_back(16'h0200);
    tick();
    flush = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check("flush_req_no_valid", 32'(instr_valid), 32'd0);
      check("flush_req_held", 32'(imem_req), 32'd1);
      tick();
      if (pc_we) break;
    end
    check("flush_req_we", 32'(pc_we), 32'd1);
    check("flush_req_drop", 32'(instr_valid), 32'd0);
    check("no_err_yet", 32'(fetch_err), 32'd0);
    ack_delay = 0;

    // Flush during UPDATE extends the strobe with the new target
    wait_valid(16'h0200);
    accept("seq_0201", 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 8'h00, 1'b1, 16'h0201);
    flush = 1'b1; flush_target = 16'h0500;
    exp_pc.push_back(16'h0500);
    ack_delay = -1;
    tick();
    check("flush_upd_we", 32'(pc_we), 32'd1);
    flush = 1'b0;

    // Memory never acks: timeout, sticky error, retry at the same address
    req_cnt = 0;
    exp_pc.push_back(16'h0500);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (pc_we) break;
      if (imem_req) req_cnt++;
    end
    check("timeout_req_cycles", 32'(req_cnt), 32'd15);
    check("timeout_we", 32'(pc_we), 32'd1);
    check("timeout_err", 32'(fetch_err), 32'd1);
    check("timeout_req_drop", 32'(imem_req), 32'd0);
    tick();
    check("retry_req", 32'(imem_req), 32'd1);
    check("retry_addr", 32'(imem_addr), 32'h0500);
    tick(); tick(); tick();
    check("err_sticky", 32'(fetch_err), 32'd1);
    check("retry_still_req", 32'(imem_req), 32'd1);
    check("sb_drained", 32'(exp_pc.size()), 32'd0);

    // Asynchronous reset mid-REQ
    #2 rst_n = 1'b0;
    #1;
    check("arst_next_pc", 32'(next_pc), 32'h0000);
    check("arst_pc_we", 32'(pc_we), 32'd0);
    check("arst_imem_req", 32'(imem_req), 32'd0);
    check("arst_instr", 32'(instr), 32'h0000);
    check("arst_instr_valid", 32'(instr_valid), 32'd0);
    check("arst_fetch_err", 32'(fetch_err), 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
